alu_frame_tx: RTL and testbench
===============================

ALU_FRAME_TX -- requirements
Module: alu_frame_tx

Interface
REQ-001 Parameter DATA_W, default 32, operand width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter GAP_CYCLES, default 2, number of idle high cycles on sin after each frame; SHALL be at least 1.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port in_valid  input  1  request to send one operation.
REQ-006 Port in_ready  output  1  block can accept a request.
REQ-007 Port in_a  input  DATA_W  operand A.
REQ-008 Port in_b  input  DATA_W  operand B.
REQ-009 Port in_op  input  3  operation code (operation_t).
REQ-010 Port in_mode  input  2  frame mode (mode_t).
REQ-011 Port sin  output  1  serial line to ALU, idle high.
REQ-012 Port busy  output  1  frame or gap in progress.
REQ-013 Port done  output  1  one-cycle pulse at frame end.

Function
REQ-014 Packet format SHALL be 11 bits, sent in this order, one bit per clock: start 0, type bit (0 = data, 1 = control), 8 payload bits MSB first, stop 1.
REQ-015 A request SHALL be accepted on the cycle where in_valid and in_ready are both high; in_a, in_b, in_op and in_mode SHALL be captured on that cycle.
REQ-016 The start bit of the first packet SHALL appear on sin in the cycle after acceptance.
REQ-017 Data packets SHALL carry the bytes of B, most significant byte first, followed by the bytes of A, most significant byte first: DATA_W/8 packets for each operand.
REQ-018 The control packet payload SHALL be {1'b0, op[2:0], crc[3:0]}.
REQ-019 crc SHALL be CRC-4 with polynomial x^4+x+1 and initial value 0, computed MSB first over {B, A, 1'b1, op}, i.e. 2*DATA_W+4 bits; it SHALL always use the full captured operands, whatever the mode.
REQ-020 Mode NORMAL (00): all data packets, then the control packet.
REQ-021 Mode BAD_CRC (01): as NORMAL, but with all four crc bits inverted.
REQ-022 Mode SHORT (10): the last byte of A is omitted, so 2*DATA_W/8-1 data packets are sent, then the control packet.
REQ-023 Mode CTL_ONLY (11): no data packets; the control packet only.
REQ-024 State machine SHALL have states IDLE, DATA, CTL, GAP.
- IDLE to DATA on acceptance, or IDLE to CTL on acceptance when the mode is CTL_ONLY.
- DATA to CTL after the stop bit of the last data packet.
- CTL to GAP after the control stop bit.
- GAP to IDLE after GAP_CYCLES cycles.
REQ-025 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 in DATA, CTL and GAP.
REQ-026 sin SHALL be 1 in IDLE and GAP.
REQ-027 done SHALL pulse high for exactly one cycle, on the first GAP cycle.
REQ-028 Back-to-back frames with in_valid held high SHALL have start bits spaced by frame_bits + GAP_CYCLES + 1 cycles.
REQ-029 Input changes while busy SHALL NOT affect the frame in flight.

Reset
REQ-030 While rst_n is low at a clock edge, the block SHALL drive sin=1, in_ready=0, busy=0, done=0, and the state SHALL be IDLE.
REQ-031 in_ready SHALL be 1 in the first cycle after rst_n returns high.
REQ-032 Reset mid-frame SHALL abort the frame: sin=1 from the next edge, no done pulse, and no residual state.

Structure
REQ-033 operation_t (AND 000, OR 001, ADD 100, SUB 101), mode_t, PKT_BITS=11 and CRC_POLY SHALL reside in alu_pkg.
REQ-034 CRC SHALL be computed in a combinational sub-module alu_crc4, parametrised by message width.

Verification
REQ-035 rst_n low for 2 cycles: sin=1 and in_ready=0 throughout; in_ready=1 in the first cycle after release.
REQ-036 DATA_W=32, A=0, B=0, op=000, NORMAL: 99 bits total; 8 packets of 0 0 00000000 1; then control packet 0 1 0 000 1011 1; done in the next cycle.
REQ-037 Same stimulus with mode BAD_CRC: control packet crc bits = 0100; total length and done timing unchanged.
REQ-038 A=32'h11223344, B=32'hAABBCCDD, SHORT: payloads AA BB CC DD 11 22 33, then the control packet; 88 bits total.
REQ-039 rst_n low at bit 40 of a NORMAL frame: sin=1 from the next edge, done never asserted, in_ready=1 after release.
REQ-040 in_valid held high for two NORMAL frames with GAP_CYCLES=2: second start bit exactly 102 cycles after the first; the second frame's content matches its captured inputs.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU frame transmitter.
//   operation_t : ALU operation codes carried in the control packet
//   mode_t      : frame composition mode
//   state_t     : transmitter FSM states
//   PKT_BITS    : start + type + 8 payload + stop
//   CRC_POLY    : low four bits of x^4+x+1
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } operation_t;

  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'b00,
    MODE_BAD_CRC  = 2'b01,
    MODE_SHORT    = 2'b10,
    MODE_CTL_ONLY = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_CTL,
    ST_GAP
  } state_t;

  localparam int         PKT_BITS = 11;
  localparam logic [3:0] CRC_POLY = 4'b0011;

endpackage

// File: rtl/alu_crc4.sv
// Combinational CRC-4 (x^4+x+1, init 0, MSB first) over a MSG_W-bit message.
//   msg : message, bit MSG_W-1 processed first
//   crc : resulting 4-bit remainder
module alu_crc4
  import alu_pkg::*;
#(
  parameter int MSG_W = 8
) (
  input  logic [MSG_W-1:0] msg,
  output logic [3:0]       crc
);

  logic [3:0] c;

  always_comb begin
    c = 4'h0;
    for (int i = MSG_W - 1; i >= 0; i--) begin
      if (c[3] ^ msg[i]) c = {c[2:0], 1'b0} ^ CRC_POLY;
      else               c = {c[2:0], 1'b0};
    end
    crc = c;
  end

endmodule

// File: rtl/alu_frame_tx.sv
// Serialises one ALU request into 11-bit packets on sin: the bytes of B then
// A (MSB first) as data packets, followed by a control packet carrying the
// opcode and a CRC-4, then GAP_CYCLES idle-high cycles.
//   clk, rst_n       : clock, synchronous active-low reset
//   in_valid/in_ready: request handshake; operands captured on acceptance
//   in_a, in_b       : operands
//   in_op, in_mode   : operation code, frame mode
//   sin              : serial output, idle high
//   busy             : frame or gap in progress
//   done             : one-cycle pulse on the first gap cycle
module alu_frame_tx
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [2:0]        in_op,
  input  logic [1:0]        in_mode,
  output logic              sin,
  output logic              busy,
  output logic              done
);

  localparam int NBYTES = DATA_W / 8;
  localparam int PKT_W  = $clog2(2 * NBYTES + 1);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [PKT_W-1:0] N_FULL  = PKT_W'(2 * NBYTES);
  localparam logic [PKT_W-1:0] N_SHORT = PKT_W'(2 * NBYTES - 1);

  state_t             state_q, state_d;
  logic [3:0]         bit_q;
  logic [PKT_W-1:0]   pkt_q;
  logic [GAP_W-1:0]   gap_q;

  logic [DATA_W-1:0]  a_q, b_q;
  logic [2:0]         op_q;
  mode_t              mode_q;

  logic               accept;
  logic               last_bit;
  logic               last_pkt;
  logic [PKT_W-1:0]   n_data;
  logic [3:0]         crc;
  logic [3:0]         crc_tx;
  logic [2*DATA_W-1:0] ba_sh;
  logic [7:0]         payload;

  assign accept   = in_valid && in_ready;
  assign last_bit = (bit_q == 4'(PKT_BITS - 1));
  assign n_data   = (mode_q == MODE_SHORT) ? N_SHORT : N_FULL;
  assign last_pkt = (pkt_q == (n_data - PKT_W'(1)));

  // CRC always spans the full captured operands, independent of mode.
  alu_crc4 #(.MSG_W(2 * DATA_W + 4)) u_crc (
    .msg ({b_q, a_q, 1'b1, op_q}),
    .crc (crc)
  );

  assign crc_tx = (mode_q == MODE_BAD_CRC) ? ~crc : crc;

  // Data byte k of {B, A}, MSB first, is brought to the top by a byte shift.
  assign ba_sh   = {b_q, a_q} << (8 * pkt_q);
  assign payload = (state_q == ST_CTL) ? {1'b0, op_q, crc_tx}
                                       : ba_sh[2*DATA_W-1 -: 8];

  // Request capture (data path, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= in_a;
      b_q    <= in_b;
      op_q   <= in_op;
      mode_q <= mode_t'(in_mode);
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bit_q   <= 4'd0;
      pkt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == ST_DATA || state_q == ST_CTL)
        bit_q <= last_bit ? 4'd0 : bit_q + 4'd1;
      else
        bit_q <= 4'd0;

      if (state_q == ST_IDLE)
        pkt_q <= '0;
      else if (state_q == ST_DATA && last_bit)
        pkt_q <= pkt_q + PKT_W'(1);

      if (state_q == ST_GAP) gap_q <= gap_q + GAP_W'(1);
      else                   gap_q <= '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)
                 state_d = (in_mode == MODE_CTL_ONLY) ? ST_CTL : ST_DATA;
      ST_DATA: if (last_bit && last_pkt) state_d = ST_CTL;
      ST_CTL:  if (last_bit) state_d = ST_GAP;
      ST_GAP:  if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // rst_n gates ready so nothing is accepted or advertised during reset.
  assign in_ready = rst_n && (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_GAP) && (gap_q == '0);

  always_comb begin
    sin = 1'b1;
    if (state_q == ST_DATA || state_q == ST_CTL) begin
      case (bit_q)
        4'd0:    sin = 1'b0;
        4'd1:    sin = (state_q == ST_CTL);
        4'd10:   sin = 1'b1;
        default: sin = payload[3'(4'd9 - bit_q)];
      endcase
    end
  end

endmodule

// File: tb/tb_alu_frame_tx.sv
// Self-checking bench for alu_frame_tx (DATA_W=32, GAP_CYCLES=2).
module tb_alu_frame_tx;

  localparam int DATA_W = 32;
  localparam int GAP    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a, in_b;
  logic [2:0]        in_op;
  logic [1:0]        in_mode;
  logic              sin, busy, done;

  int tests = 0;
  int fails = 0;

  bit   exp_q[$];
  logic obs_q[$];

  alu_frame_tx #(.DATA_W(DATA_W), .GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_op    (in_op),
    .in_mode  (in_mode),
    .sin      (sin),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: packets as lists of bits.
  function automatic void push_pkt(bit t, logic [7:0] pl);
    exp_q.push_back(1'b0);
    exp_q.push_back(t);
    for (int j = 7; j >= 0; j--) exp_q.push_back(pl[j]);
    exp_q.push_back(1'b1);
  endfunction

  function automatic logic [3:0] ref_crc(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    logic [71:0] m;
    m = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  function automatic void push_frame(logic [31:0] a, logic [31:0] b,
                                     logic [2:0] op, logic [1:0] mode);
    logic [7:0] bytes[$];
    logic [3:0] c;
    for (int k = 0; k < 4; k++) bytes.push_back(b[31-8*k -: 8]);
    for (int k = 0; k < 4; k++) bytes.push_back(a[31-8*k -: 8]);
    if (mode == 2'b10) void'(bytes.pop_back());
    if (mode == 2'b11) bytes.delete();
    foreach (bytes[j]) push_pkt(1'b0, bytes[j]);
    c = ref_crc(a, b, op);
    if (mode == 2'b01) c = ~c;
    push_pkt(1'b1, {1'b0, op, c});
  endfunction

  task automatic compare_stream(string tag);
    int bad;
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
    check({tag, "_len"}, obs_q.size(), exp_q.size());
    check({tag, "_first_bad_bit"}, bad, -1);
  endtask

  function automatic logic [10:0] last_pkt_obs();
    logic [10:0] v;
    v = '0;
    for (int i = obs_q.size() - 11; i < obs_q.size(); i++) v = {v[9:0], obs_q[i]};
    return v;
  endfunction

  task automatic wait_ready(string tag);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 300) begin
      tick();
      w++;
    end
    check({tag, "_ready_wait"}, in_ready, 1'b1);
  endtask

  task automatic scramble_inputs();
    in_a    = $urandom;
    in_b    = $urandom;
    in_op   = 3'($urandom);
    in_mode = 2'($urandom);
  endtask

  task automatic run_frame(string tag, logic [31:0] a, logic [31:0] b,
                           logic [2:0] op, logic [1:0] mode);
    int n;
    bit early_done, busy_low;
    exp_q.delete();
    obs_q.delete();
    push_frame(a, b, op, mode);
    n = exp_q.size();
    wait_ready(tag);
    in_a = a; in_b = b; in_op = op; in_mode = mode; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    scramble_inputs();
    early_done = 0;
    busy_low   = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      obs_q.push_back(sin);
      if (done !== 1'b0) early_done = 1;
      if (busy !== 1'b1) busy_low = 1;
    end
    compare_stream(tag);
    check({tag, "_early_done"}, early_done, 1'b0);
    check({tag, "_busy_in_frame"}, busy_low, 1'b0);
    tick();
    check({tag, "_done_pulse"}, {done, sin, busy}, 3'b111);
    tick();
    check({tag, "_gap2"}, {done, sin, busy, in_ready}, 4'b0110);
    tick();
    check({tag, "_idle_ready"}, {in_ready, busy, sin}, 3'b101);
  endtask

  initial begin
    bit done_seen, sin_low;
    int second_start;
    logic [31:0] a1, b1, a2, b2;
    logic [2:0]  op1, op2;

    rst_n = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_mode = '0;

    // Reset: two cycles low
    tick();
    check("rst_cyc1", {sin, in_ready, busy, done}, 4'b1000);
    tick();
    check("rst_cyc2", {sin, in_ready, busy, done}, 4'b1000);
    rst_n = 1'b1;
    tick();
    check("ready_after_release", in_ready, 1'b1);

    // All-zero NORMAL frame and BAD_CRC variant
    run_frame("zero_normal", 32'h0, 32'h0, 3'b000, 2'b00);
    check("zero_normal_ctl", last_pkt_obs(), 11'b01000010111);
    run_frame("zero_badcrc", 32'h0, 32'h0, 3'b000, 2'b01);
    check("zero_badcrc_ctl", last_pkt_obs(), 11'b01000001001);
    check("zero_badcrc_len", obs_q.size(), 99);

    // SHORT frame: payloads AA BB CC DD 11 22 33
    run_frame("short", 32'h11223344, 32'hAABBCCDD, 3'b100, 2'b10);
    check("short_total_bits", obs_q.size(), 88);

    run_frame("ctl_only", $urandom, $urandom, 3'b101, 2'b11);

    // Randomised frames
    for (int r = 0; r < 10; r++)
      run_frame($sformatf("rand%0d", r), $urandom, $urandom,
                3'($urandom), 2'($urandom));

    // Reset at bit 40 of a NORMAL frame
    wait_ready("midrst");
    in_a = $urandom; in_b = $urandom; in_op = 3'b001; in_mode = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 40; i++) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_outputs", {sin, busy, done, in_ready}, 4'b1000);
    rst_n = 1'b1;
    tick();
    check("midrst_ready_after_release", in_ready, 1'b1);
    done_seen = 0;
    sin_low   = 0;
    for (int i = 0; i < 110; i++) begin
      if (done !== 1'b0) done_seen = 1;
      if (sin !== 1'b1) sin_low = 1;
      tick();
    end
    check("midrst_no_done", done_seen, 1'b0);
    check("midrst_sin_idle", sin_low, 1'b0);

    // Back-to-back frames with in_valid held high
    a1 = $urandom; b1 = $urandom; op1 = 3'b100;
    a2 = $urandom; b2 = $urandom; op2 = 3'b101;
    exp_q.delete();
    obs_q.delete();
    push_frame(a1, b1, op1, 2'b00);
    for (int i = 0; i < GAP + 1; i++) exp_q.push_back(1'b1);
    push_frame(a2, b2, op2, 2'b00);
    exp_q.push_back(1'b1);
    wait_ready("b2b");
    in_a = a1; in_b = b1; in_op = op1; in_mode = 2'b00; in_valid = 1'b1;
    tick();
    in_a = a2; in_b = b2; in_op = op2;
    for (int i = 0; i < 202; i++) begin
      if (i > 0) tick();
      obs_q.push_back(sin);
      if (i == 102) in_valid = 1'b0;
    end
    check("b2b_done_second", done, 1'b1);
    compare_stream("b2b");
    second_start = -1;
    for (int i = 99; i < obs_q.size(); i++)
      if (second_start < 0 && obs_q[i] === 1'b0) second_start = i;
    check("b2b_start_spacing", second_start, 102);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
